seq_restoring_divider: RTL and testbench
========================================

# seq_restoring_divider

Sequential radix-2 restoring divider that computes quotient and remainder of two WIDTH-bit operands, one quotient bit per clock. It is the divide counterpart of the team's combinational multiplier arrays. It serves datapaths where a divide is rare enough that a multi-cycle unit with a start/done handshake is preferable to a full array. Internally each iteration uses a single (WIDTH+1)-bit subtractor built from the same full-adder cells as the multipliers.

## Interface
- WIDTH, 8, operand and result width in bits (minimum 2)
- clk  input  1  rising-edge clock; the single clock of the block
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- dividend  input  WIDTH  numerator, captured on the accepting edge
- divisor  input  WIDTH  denominator, captured on the accepting edge
- busy  output  1  high in RUN and DONE; reset 0
- done  output  1  one-cycle pulse when results are valid; reset 0
- quotient  output  WIDTH  result quotient; reset 0
- remainder  output  WIDTH  result remainder; reset 0
- div_by_zero  output  1  set with done when the captured divisor was 0; reset 0

## Operation
- FSM states: IDLE, RUN, DONE. Reset enters IDLE.
- IDLE with start=1 and divisor≠0:
  - capture the operands
  - clear the partial remainder R (WIDTH+1 bits)
  - load the quotient shift register Q with the dividend
  - load the iteration counter with WIDTH
  - go to RUN
- IDLE with start=1 and divisor=0: go directly to DONE with quotient = all ones, remainder = dividend, div_by_zero = 1.
- RUN iteration, each cycle:
  - T = {R[WIDTH-1:0], Q[WIDTH-1]} − {1'b0, divisor}
  - if T is non-negative (T[WIDTH]=0): R = T and shift 1 into Q
  - else: R = {R[WIDTH-1:0], Q[WIDTH-1]} (restore) and shift 0 into Q
  - decrement the counter; after the WIDTH-th iteration go to DONE
- DONE lasts one cycle:
  - register quotient = Q and remainder = R[WIDTH-1:0]
  - set done = 1, then return to IDLE
- quotient, remainder and div_by_zero hold their values until the next accepted start. div_by_zero clears on any accepted start with a non-zero divisor.
- start is ignored while busy. There is no queueing, and operand changes during RUN have no effect.
- Results are exact unsigned floor division: dividend = quotient·divisor + remainder, with remainder < divisor.

## Timing
- Accepting edge = edge n. busy rises after edge n.
- Non-zero divisor: done is high during the cycle following edge n+WIDTH+1, i.e. latency WIDTH+1 cycles from accept to done. Results become valid on the same edge that raises done.
- Zero divisor: done is high after edge n+1, with latency 1 cycle.
- busy falls on the same edge that drops done. A start held high in that IDLE cycle is accepted immediately, so back-to-back throughput is one divide per WIDTH+2 cycles.
- rst_n assertion at any time, including mid-RUN, immediately drives every output to 0 and the FSM to IDLE. The partial result is discarded and no done is produced.

## Configuration
- DIVIDER_SIGNED_EN defined: operands and results are two's complement.
  - At accept, operand magnitudes are taken and the sign flags are stored.
  - In DONE, the quotient is negated if the operand signs differ, and the remainder takes the sign of the dividend (truncation toward zero).
  - −2^(WIDTH-1) / −1 wraps to quotient −2^(WIDTH-1), remainder 0.
  - Divide by zero gives quotient = all ones (−1) and remainder = dividend.
  - Latency is unchanged.
- Not defined: unsigned only. No sign logic is synthesized.

## Test plan (WIDTH=8)
- Unsigned divide: start with 100 / 7. Expect quotient 14, remainder 2, div_by_zero 0, done exactly 9 cycles after accept, and busy high for those 9 cycles.
- Zero divisor: 5 / 0. Expect done 1 cycle after accept, quotient 0xFF, remainder 5, div_by_zero 1. A following 255 / 1 must give quotient 255, remainder 0, div_by_zero 0.
- Ignored start: assert start with 200 / 3 during RUN of 50 / 6. Expect a single done with quotient 8, remainder 2, and no second operation.
- Reset mid-RUN: pulse rst_n low 4 cycles after accepting 77 / 5. Expect all outputs 0 asynchronously and no done. A new 77 / 5 afterwards gives 15 r 2.
- Back-to-back and hold: hold start high continuously with 9 / 10 (expect 0 r 9) then 10 / 10 (expect 1 r 0). Expect accepts exactly 10 cycles apart, with results held between the done pulses.
- DIVIDER_SIGNED_EN: −100 / 7 gives quotient 0xF2 (−14), remainder 0xFE (−2). 0x80 / 0xFF gives quotient 0x80, remainder 0.

Source files
------------

// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: radix-2 restoring divider, one quotient bit per clock, start/done handshake.
// Define DIVIDER_SIGNED_EN for two's complement operands (truncating division); default is unsigned.
module seq_restoring_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [WIDTH:0] t;
  logic [WIDTH-1:0] r, q, dvs, dvd_mag, dvs_mag, q_fix, r_fix;
  logic [CW-1:0] cnt;
  logic zero_pend;
`ifdef DIVIDER_SIGNED_EN
  logic neg_q, neg_r;
  always_comb begin
    dvd_mag = dividend[WIDTH-1] ? -dividend : dividend;
    dvs_mag = divisor[WIDTH-1] ? -divisor : divisor;
    q_fix = neg_q ? -q : q;
    r_fix = neg_r ? -r : r;
  end
`else
  always_comb begin
    dvd_mag = dividend;
    dvs_mag = divisor;
    q_fix = q;
    r_fix = r;
  end
`endif
  // A partial remainder below the divisor always fits WIDTH bits after the shift when restoring.
  assign t = {r, q[WIDTH-1]} - {1'b0, dvs};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      quotient <= '0;
      remainder <= '0;
      div_by_zero <= 1'b0;
      r <= '0;
      q <= '0;
      dvs <= '0;
      cnt <= '0;
      zero_pend <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      neg_q <= 1'b0;
      neg_r <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          busy <= start;
          if (start && divisor == '0) begin
            state <= DONE;
            q <= '1;
            r <= dividend;
            zero_pend <= 1'b1;
`ifdef DIVIDER_SIGNED_EN
            neg_q <= 1'b0;
            neg_r <= 1'b0;
`endif
          end else if (start) begin
            state <= RUN;
            q <= dvd_mag;
            r <= '0;
            dvs <= dvs_mag;
            cnt <= CW'(WIDTH);
            zero_pend <= 1'b0;
            div_by_zero <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
            neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_r <= dividend[WIDTH-1];
`endif
          end
        end
        RUN: begin
          r <= t[WIDTH] ? {r[WIDTH-2:0], q[WIDTH-1]} : t[WIDTH-1:0];
          q <= {q[WIDTH-2:0], ~t[WIDTH]};
          cnt <= cnt - 1'b1;
          state <= (cnt == CW'(1)) ? DONE : RUN;
        end
        DONE: begin
          done <= 1'b1;
          quotient <= q_fix;
          remainder <= r_fix;
          div_by_zero <= zero_pend;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb_seq_restoring_divider: directed plus random checks of seq_restoring_divider (WIDTH=8) against an arithmetic model.
module tb_seq_restoring_divider;
  logic clk = 1'b0;
  logic rst_n, start, busy, done, div_by_zero;
  logic [7:0] dividend, divisor, quotient, remainder;
  int checks = 0;
  int errors = 0;
  int k, ndone;
  bit bz;

  seq_restoring_divider #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [7:0] a, input logic [7:0] b,
                                output logic [7:0] q, output logic [7:0] r, output logic z);
`ifdef DIVIDER_SIGNED_EN
    int sa, sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
`endif
    if (b == 8'd0) begin
      q = 8'hFF;
      r = a;
      z = 1'b1;
    end else begin
`ifdef DIVIDER_SIGNED_EN
      q = 8'(sa / sb);
      r = 8'(sa % sb);
`else
      q = a / b;
      r = a % b;
`endif
      z = 1'b0;
    end
  endfunction

  task automatic accept(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    start = 1'b1;
    dividend = a;
    divisor = b;
    @(negedge clk);
    start = 1'b0;
    dividend = 8'($urandom);
    divisor = 8'($urandom);
  endtask

  task automatic wait_done(output int n, output bit all_busy);
    n = 0;
    all_busy = 1'b1;
    while (done !== 1'b1 && n < 20) begin
      if (busy !== 1'b1) all_busy = 1'b0;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic check_res(input string tag, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] eq, er;
    logic ez;
    model(a, b, eq, er, ez);
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_q"}, quotient, eq);
    chk({tag, "_r"}, remainder, er);
    chk({tag, "_dbz"}, div_by_zero, ez);
  endtask

  task automatic run_div(input string tag, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] eq, er;
    logic ez;
    model(a, b, eq, er, ez);
    accept(a, b);
    wait_done(k, bz);
    chk({tag, "_lat"}, k, (b == 8'd0) ? 1 : 9);
    chk({tag, "_busy"}, bz, 1'b1);
    check_res(tag, a, b);
    @(negedge clk);
    chk({tag, "_done_drop"}, done, 1'b0);
    chk({tag, "_busy_drop"}, busy, 1'b0);
    chk({tag, "_q_hold"}, quotient, eq);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    #12;
    chk("rst_outs", {busy, done, quotient, remainder, div_by_zero}, '0);
    @(negedge clk);
    rst_n = 1'b1;

    run_div("u100_7", 8'd100, 8'd7);
`ifndef DIVIDER_SIGNED_EN
    chk("u100_7_const", {quotient, remainder}, {8'd14, 8'd2});
`endif
    run_div("zero", 8'd5, 8'd0);
    run_div("u255_1", 8'd255, 8'd1);

    // start raised mid-RUN must be ignored
    accept(8'd50, 8'd6);
    repeat (3) @(negedge clk);
    start = 1'b1;
    dividend = 8'd200;
    divisor = 8'd3;
    repeat (2) @(negedge clk);
    start = 1'b0;
    wait_done(k, bz);
    chk("ign_lat", k + 5, 9);
    check_res("ign", 8'd50, 8'd6);
    ndone = 0;
    repeat (15) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) ndone++;
    end
    chk("ign_no_second", ndone, 0);

    // asynchronous reset in the middle of RUN
    accept(8'd77, 8'd5);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_outs", {busy, done, quotient, remainder, div_by_zero}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (15) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    chk("midrst_no_done", ndone, 0);
    run_div("u77_5", 8'd77, 8'd5);

    // start held high: accepts 10 cycles apart
    @(negedge clk);
    start = 1'b1;
    dividend = 8'd9;
    divisor = 8'd10;
    @(negedge clk);
    wait_done(k, bz);
    chk("b2b1_lat", k, 9);
    check_res("b2b1", 8'd9, 8'd10);
    dividend = 8'd10;
    divisor = 8'd10;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_reaccept_busy", busy, 1'b1);
    chk("b2b_reaccept_done", done, 1'b0);
    chk("b2b_hold", {quotient, remainder}, {8'd0, 8'd9});
    wait_done(k, bz);
    chk("b2b2_lat", k, 9);
    check_res("b2b2", 8'd10, 8'd10);
    @(negedge clk);
    chk("b2b_busy_drop", busy, 1'b0);

`ifdef DIVIDER_SIGNED_EN
    run_div("s_m100_7", 8'h9C, 8'd7);
    chk("s_m100_7_const", {quotient, remainder}, {8'hF2, 8'hFE});
    run_div("s_ovf", 8'h80, 8'hFF);
    chk("s_ovf_const", {quotient, remainder}, {8'h80, 8'h00});
`endif

    for (int i = 0; i < 16; i++) begin
      logic [7:0] a, b;
      a = 8'($urandom);
      b = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
      run_div($sformatf("rnd%0d", i), a, b);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
